// File: rtl/uart_tx_serializer.sv
// UART TX serializer: pops one byte per frame from the TX FIFO and shifts it out as
// start, 7/8 data bits LSB first, optional parity, and one stop bit, paced by a 16x baud enable.
module uart_tx_serializer #(
  parameter int RD_LATENCY = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       baud_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_n,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // state   | meaning
  // IDLE    | line idle, waiting for FIFO data
  // RD_STB  | single-cycle FIFO read strobe
  // RD_WAIT | wait out FIFO read latency, capture byte and config on last cycle
  // START   | start bit (low)
  // DATA    | data bits, LSB first
  // PARITY  | parity bit
  // STOP    | stop bit (high), then next byte or idle
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_STB  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] START   = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] PARITY  = 3'd5;
  localparam logic [2:0] STOP    = 3'd6;

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LOAD = TW'(OVERSAMPLE - 1);
  localparam logic [1:0]    LAT_LOAD  = 2'(RD_LATENCY - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    lat_q, lat_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit8_q, bit8_d;
  logic          par_en_q, par_en_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          rd_n_q, rd_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timing, bit_end;

  assign timing  = (state_q == START) || (state_q == DATA) ||
                   (state_q == PARITY) || (state_q == STOP);
  assign bit_end = timing && baud_tick && (tick_q == '0);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    lat_d    = lat_q;
    shift_d  = shift_q;
    bit8_d   = bit8_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    done_d   = 1'b0;

    // tick counter runs down; a bit ends on the tick seen at zero
    if (timing && baud_tick && (tick_q != '0))
      tick_d = tick_q - TW'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = RD_STB;
      end
      RD_STB: begin
        lat_d   = LAT_LOAD;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == 2'd0) begin
          shift_d  = fifo_data;
          bit8_d   = bit8;
          par_en_d = parity_en;
          par_d    = (^(fifo_data & {bit8, 7'h7f})) ^ odd_n_even;
          tick_d   = TICK_LOAD;
          state_d  = START;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      START: begin
        if (bit_end) begin
          tick_d  = TICK_LOAD;
          bit_d   = bit8_q ? 3'd7 : 3'd6;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d  = TICK_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd0) state_d = par_en_q ? PARITY : STOP;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          tick_d  = TICK_LOAD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = fifo_empty ? IDLE : RD_STB;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
    rd_n_d = (state_d != RD_STB);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= 3'd0;
      lat_q    <= 2'd0;
      shift_q  <= 8'h00;
      bit8_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      rd_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      lat_q    <= lat_d;
      shift_q  <= shift_d;
      bit8_q   <= bit8_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      rd_n_q   <= rd_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_rd_n = rd_n_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: FIFO model with 2-cycle read latency,
// baud tick every 4 CLKs, frames decoded by counting ticks and sampling mid-bit.
module tb_uart_tx_serializer;
  localparam int RDL = 2;
  localparam int OVS = 16;

  logic       CLK, RESET_N, baud_tick, fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_n, bit8, parity_en, odd_n_even, tx, tx_busy, tx_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fq[$];
  logic [7:0] pipe1;
  logic       rd_seen;
  int         strobes    = 0;
  int         underflows = 0;

  logic [11:0] cap_sym;
  int          cap_gap, cap_done_in, cap_cyc;
  logic        cap_to, cap_done_end, cap_busy_end, cap_rd_end;
  int          chg[$];

  uart_tx_serializer #(.RD_LATENCY(RDL), .OVERSAMPLE(OVS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .baud_tick(baud_tick), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_n(fifo_rd_n), .bit8(bit8), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge CLK);
      #1 baud_tick = 1'b1;
      @(posedge CLK);
      #1 baud_tick = 1'b0;
    end
  end

  initial begin
    rd_seen = 1'b0;
    forever begin
      @(negedge CLK);
      rd_seen = !fifo_rd_n;
    end
  end

  // FIFO: strobe sampled at edge E0, DO register valid during the second cycle after the strobe
  initial begin
    fifo_data  = 8'h00;
    pipe1      = 8'h00;
    fifo_empty = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      fifo_data = pipe1;
      if (rd_seen === 1'b1) begin
        strobes++;
        if (fq.size() == 0) underflows++;
        else pipe1 = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int total, input int stop_at, input bit flip);
    int   t, ticks, cyc;
    logic prev;
    bit   flipped, run;
    cap_to       = 1'b0;
    cap_sym      = '0;
    cap_done_in  = 0;
    cap_done_end = 1'b0;
    cap_busy_end = 1'b1;
    cap_rd_end   = 1'b1;
    chg.delete();
    t = 0;
    while (tx !== 1'b0 && t < 4000) begin
      @(negedge CLK);
      t++;
    end
    cap_gap = t;
    if (tx !== 1'b0) begin
      cap_to = 1'b1;
      return;
    end
    ticks = 0; cyc = 0; prev = tx; flipped = 0; run = 1;
    while (run) begin
      if (baud_tick === 1'b1) begin
        ticks++;
        if (ticks % OVS == OVS / 2) cap_sym[ticks / OVS] = tx;
      end
      if (flip && !flipped && ticks >= 24) begin
        bit8 = ~bit8; parity_en = ~parity_en; odd_n_even = ~odd_n_even;
        flipped = 1;
      end
      if (tx_done === 1'b1) cap_done_in++;
      if (ticks >= total * OVS || (stop_at != 0 && ticks >= stop_at)) run = 0;
      else if (cyc >= 6000) begin
        cap_to = 1'b1;
        run = 0;
      end else begin
        @(negedge CLK);
        cyc++;
        if (tx !== prev) begin
          chg.push_back(cyc);
          prev = tx;
        end
      end
    end
    cap_cyc = cyc;
    if (stop_at == 0 && !cap_to) begin
      @(negedge CLK);
      cap_done_end = tx_done;
      cap_busy_end = tx_busy;
      cap_rd_end   = fifo_rd_n;
    end
  endtask

  initial begin
    int s0, bad;
    RESET_N = 1'b0; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_rd_n", 32'(fifo_rd_n), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    #2 RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("idle_tx", 32'(tx), 32'd1);

    // 8N1 0x55
    s0 = strobes;
    fq.push_back(8'h55);
    capture(10, 0, 0);
    chk("t1_timeout", 32'(cap_to), 32'd0);
    chk("t1_frame", 32'(cap_sym), 32'h2AA);
    chk("t1_edges", 32'(chg.size()), 32'd9);
    bad = 0;
    for (int i = 0; i + 1 < chg.size(); i++) if (chg[i+1] - chg[i] != 64) bad++;
    chk("t1_bitlen", 32'(bad), 32'd0);
    chk("t1_done_inside", 32'(cap_done_in), 32'd0);
    chk("t1_done_end", 32'(cap_done_end), 32'd1);
    chk("t1_busy_end", 32'(cap_busy_end), 32'd0);
    chk("t1_strobes", 32'(strobes - s0), 32'd1);

    // 7O1 0xC3, config flipped mid-frame must not matter
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
    fq.push_back(8'hC3);
    capture(10, 0, 1);
    chk("t2_timeout", 32'(cap_to), 32'd0);
    chk("t2_frame", 32'(cap_sym), 32'h286);
    chk("t2_done_end", 32'(cap_done_end), 32'd1);

    // 8E1 0x07
    bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
    fq.push_back(8'h07);
    capture(11, 0, 0);
    chk("t3_timeout", 32'(cap_to), 32'd0);
    chk("t3_frame", 32'(cap_sym), 32'h60E);
    chk("t3_busy_end", 32'(cap_busy_end), 32'd0);

    // back-to-back 0x01,0x02,0x03
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    s0 = strobes;
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    capture(10, 0, 0);
    chk("t4_f0_frame", 32'(cap_sym), 32'h202);
    chk("t4_f0_rd_end", 32'(cap_rd_end), 32'd0);
    chk("t4_f0_busy_end", 32'(cap_busy_end), 32'd1);
    capture(10, 0, 0);
    chk("t4_f1_gap", 32'(cap_gap), 32'(RDL + 1));
    chk("t4_f1_frame", 32'(cap_sym), 32'h204);
    capture(10, 0, 0);
    chk("t4_f2_gap", 32'(cap_gap), 32'(RDL + 1));
    chk("t4_f2_frame", 32'(cap_sym), 32'h206);
    chk("t4_f2_rd_end", 32'(cap_rd_end), 32'd1);
    chk("t4_f2_busy_end", 32'(cap_busy_end), 32'd0);
    chk("t4_strobes", 32'(strobes - s0), 32'd3);

    // empty FIFO for 1000 CLKs
    s0 = strobes;
    bad = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (fifo_rd_n !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("t5_idle_bad", 32'(bad), 32'd0);
    chk("t5_strobes", 32'(strobes - s0), 32'd0);

    // reset mid-frame during data bit 3 of 0xFF
    s0 = strobes;
    bit8 = 1'b1; parity_en = 1'b0;
    fq.push_back(8'hFF);
    capture(10, 72, 0);
    chk("t6_timeout", 32'(cap_to), 32'd0);
    chk("t6_pre_busy", 32'(tx_busy), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(tx), 32'd1);
    chk("t6_rst_busy", 32'(tx_busy), 32'd0);
    chk("t6_rst_rd_n", 32'(fifo_rd_n), 32'd1);
    fq.push_back(8'hA5);
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b1;
    capture(10, 0, 0);
    chk("t6_timeout2", 32'(cap_to), 32'd0);
    chk("t6_frame", 32'(cap_sym), 32'h34A);
    chk("t6_done_end", 32'(cap_done_end), 32'd1);
    chk("t6_strobes", 32'(strobes - s0), 32'd2);
    chk("underflows", 32'(underflows), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
